slow_mem_responder: RTL and testbench
=====================================

Name: slow_mem_responder

Overview:
- Memory-side responder for the cache-to-slow-memory line interface: mem_read, mem_write, mem_addr[31:4], mem_wdata[127:0], mem_rdata[127:0], mem_ready.
- Sits outside the chip, one instance for the D side and one for the I side.
- Accepts one 128-bit line request at a time, waits a fixed latency, then pulses mem_ready for one cycle, with read data valid in that cycle.
- Backed by a 2^ADDR_BITS x 128-bit storage array; used for simulation and FPGA bring-up.

Parameters:
- ADDR_BITS, 8: line-index width; array depth is 2^ADDR_BITS lines; index = mem_addr[ADDR_BITS+3:4].
- LATENCY, 8: cycles from request acceptance to mem_ready; legal range 1..255.

Ports:
- clk  in  1  single clock; everything is posedge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  line read request, held high by the cache until mem_ready is seen.
- mem_write  in  1  line write request, held high by the cache until mem_ready is seen.
- mem_addr  in  28  line address [31:4]; bits above the index are ignored.
- mem_wdata  in  128  write line data.
- mem_rdata  out  128  read line data, registered.
- mem_ready  out  1  one-cycle completion pulse.
- busy  out  1  high while a transaction is in flight.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; mem_ready=0, mem_rdata=0, busy=0, err=0; counter=0.
  - Array contents are not reset.
- State machine:
  - IDLE: on a posedge with mem_read|mem_write=1, latch addr, wdata and op; load counter with LATENCY-1; go to BUSY; busy=1.
  - BUSY: counter decrements each cycle. At 0, go to RESP.
    - Read: mem_rdata <= array[idx], registered on the same edge as the transition.
    - Write: array[idx] <= latched wdata, on the same edge.
    - mem_ready <= 1.
  - RESP: mem_ready=1 for exactly this one cycle; next state RECOVER; mem_ready <= 0.
  - RECOVER: one cycle, requests ignored, so a request still held because the cache drops it late cannot start a duplicate transaction. Next state IDLE; busy <= 0 on leaving RECOVER.
- Latency: request sampled at edge k means mem_ready is high in the cycle following edge k+LATENCY.
- Back-to-back throughput: LATENCY+2 cycles per line.
- mem_rdata holds its value until the next read completes; writes do not change it.
- Request sampling:
  - addr, wdata and op are captured only at acceptance.
  - Input changes during BUSY, RESP or RECOVER are ignored.
  - A request dropped mid-BUSY still completes: a write still commits and mem_ready still pulses.
- Simultaneous mem_read=1 and mem_write=1 at acceptance: treated as a write; err <= 1, sticky until reset.
- Read-after-write to the same line returns the written data, because the write commits at the BUSY->RESP edge.
- Reset mid-transaction: state machine and outputs return to reset values immediately. An uncommitted write is lost; a committed write remains in the array.
- Index wrap: addresses differing only above bit ADDR_BITS+3 alias to the same line.

Optional Feature:
- Macro: SLOW_MEM_RANDLAT_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1, reset seed 8'hA5) advances once per accepted request.
  - Effective latency = LATENCY + lfsr[2:0], i.e. LATENCY..LATENCY+7.
  - Counter width is sized for LATENCY+7.
- Undefined: latency is fixed at LATENCY and no LFSR logic exists.

Test Plan:
- Reset: hold rst_n=0 mid-BUSY -> mem_ready=0, busy=0, err=0, mem_rdata=0 asynchronously. After release, a new request is accepted normally.
- Write then read, LATENCY=8:
  - mem_write at 0x0000_0120 with wdata=128'hDEAD...BEEF -> mem_ready pulses one cycle, 8 cycles after acceptance.
  - mem_read at the same address -> mem_rdata=128'hDEAD...BEEF in the mem_ready cycle.
- Held request: cache keeps mem_read=1 two cycles after mem_ready -> exactly one mem_ready pulse. The next acceptance happens only in IDLE after RECOVER.
- Address change mid-BUSY: mem_addr switches from line 0x12 to line 0x34 -> response reflects line 0x12; line 0x34 is untouched.
- Both requests asserted: mem_read=mem_write=1 -> write commits; err=1 and stays high until rst_n=0.
- Alias (ADDR_BITS=8): write line 0x001, then read line 0x101 -> same data returned.

Source files
------------

// File: rtl/slow_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : slow_mem_responder
// Description : Memory-side responder for the cache line interface. It accepts
//               one 128-bit line request at a time, waits a fixed number of
//               cycles, then pulses mem_ready for one cycle. Read data is valid
//               in that same cycle. Storage is a 2^ADDR_BITS x 128-bit array.
//               The responder is meant for simulation and FPGA bring-up.
//
// Parameters  : ADDR_BITS  line-index width; index = mem_addr[ADDR_BITS+3:4]
//               LATENCY    acceptance-to-mem_ready cycles, 1..255
//
// Ports       : clk        clock, posedge
//               rst_n      asynchronous active-low reset
//               mem_read   line read request, held until mem_ready
//               mem_write  line write request, held until mem_ready
//               mem_addr   line address [31:4]; bits above the index ignored
//               mem_wdata  write line data
//               mem_rdata  registered read line data
//               mem_ready  one-cycle completion pulse
//               busy       transaction in flight (BUSY, RESP, RECOVER)
//               err        sticky flag, set by read+write asserted together
//
// Options     : `define SLOW_MEM_RANDLAT_EN adds an 8-bit LFSR.
//               With it, each transaction's latency is LATENCY..LATENCY+7.
//
// Revision    : 1.0  initial release
// ============================================================================
module slow_mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [31:4]   mem_addr,
    input  logic [127:0]  mem_wdata,
    output logic [127:0]  mem_rdata,
    output logic          mem_ready,
    output logic          busy,
    output logic          err
);

    localparam int c_DEPTH = 2 ** ADDR_BITS;

`ifdef SLOW_MEM_RANDLAT_EN
    localparam int c_MAX_LOAD = LATENCY + 6;
`else
    localparam int c_MAX_LOAD = LATENCY - 1;
`endif
    localparam int                 c_CNT_W = (c_MAX_LOAD < 2) ? 1 : $clog2(c_MAX_LOAD + 1);
    localparam logic [c_CNT_W-1:0] c_LOAD  = c_CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RESP    = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [ADDR_BITS-1:0]   r_idx;
    logic [127:0]           r_wdata;
    logic                   r_is_write;
    logic [127:0]           r_mem [c_DEPTH];

    logic                   w_req;
    logic                   w_accept;
    logic                   w_commit;
    logic [ADDR_BITS-1:0]   w_idx;
    logic [c_CNT_W-1:0]     w_load;

    assign w_req    = mem_read | mem_write;
    assign w_accept = (r_state == S_IDLE) && w_req;
    assign w_idx    = mem_addr[ADDR_BITS+3:4];
    // A write lands on the same edge as BUSY->RESP.
    // A read issued after that edge therefore sees the new data.
    assign w_commit = (r_state == S_BUSY) && (r_cnt == '0) && r_is_write;

    // Address bits above the line index alias onto the same line
    if (ADDR_BITS < 28) begin : g_unused_addr
        logic w_unused;
        assign w_unused = ^mem_addr[31:ADDR_BITS+4];
    end

`ifdef SLOW_MEM_RANDLAT_EN
    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, stepped once per accepted request
    logic [7:0] r_lfsr;
    logic       w_fb;

    assign w_fb   = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign w_load = c_LOAD + c_CNT_W'(r_lfsr[2:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 8'hA5;
        end else if (w_accept) begin
            r_lfsr <= {r_lfsr[6:0], w_fb};
        end
    end
`else
    assign w_load = c_LOAD;
`endif

    // The storage array is not reset, so its contents survive rst_n.
    // A write already committed before reset remains in the array.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_is_write <= 1'b0;
            mem_rdata  <= '0;
            mem_ready  <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_idx      <= w_idx;
                        r_wdata    <= mem_wdata;
                        // Read and write asserted together are treated as a write
                        r_is_write <= mem_write;
                        r_cnt      <= w_load;
                        busy       <= 1'b1;
                        if (mem_read && mem_write) begin
                            err <= 1'b1;
                        end
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        if (!r_is_write) begin
                            mem_rdata <= r_mem[r_idx];
                        end
                        mem_ready <= 1'b1;
                        r_state   <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    mem_ready <= 1'b0;
                    r_state   <= S_RECOVER;
                end
                S_RECOVER: begin
                    // This extra cycle lets the cache drop a request it still
                    // holds, so that request does not start a second transaction.
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slow_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_slow_mem_responder
// Description : Directed self-checking bench for slow_mem_responder using the
//               default geometry (ADDR_BITS=8, LATENCY=8).
// Revision    : 1.0  initial release
// ============================================================================
module tb_slow_mem_responder;

    localparam int c_LAT = 8;

    logic          clk;
    logic          rst_n;
    logic          mem_read;
    logic          mem_write;
    logic [31:4]   mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata;
    logic          mem_ready;
    logic          busy;
    logic          err;

    int n_assert = 0;
    int n_fail   = 0;

    slow_mem_responder #(
        .ADDR_BITS (8),
        .LATENCY   (c_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, expected end before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one transaction: it drives the request and measures the latency.
    // It checks that mem_ready is a single pulse. The request may be held
    // for 'hold' cycles after mem_ready. If chg is set, address and data are
    // changed mid-BUSY. The read data seen in the mem_ready cycle is returned.
    task automatic run(input string tag, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [127:0] wd,
                       input int hold, input bit chg, output logic [127:0] rdata);
        int cnt;
        int pulses;
        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = addr[31:4];
        mem_wdata = wd;
        @(posedge clk); #1;
        chk({tag, "/busy_on_accept"}, 128'(busy), 128'(1));
        cnt = 0;
        while (!mem_ready && cnt < 40) begin
            if (chg && cnt == 3) begin
                mem_addr  = 28'h0000_034;
                mem_wdata = ~wd;
            end
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, "/latency"}, 128'(cnt), 128'(c_LAT));
        rdata  = mem_rdata;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (i >= hold) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
            @(posedge clk); #1;
            if (mem_ready) pulses++;
        end
        chk({tag, "/extra_pulses"}, 128'(pulses), 128'(0));
        chk({tag, "/busy_idle_after"}, 128'(busy), 128'(0));
    endtask

    localparam logic [127:0] c_D1  = 128'hDEADBEEF_00112233_44556677_CAFEBEEF;
    localparam logic [127:0] c_D2  = 128'h12121212_34343434_56565656_78787878;
    localparam logic [127:0] c_D34 = 128'h34343434_AAAAAAAA_55555555_0F0F0F0F;
    localparam logic [127:0] c_D3  = 128'h0BADF00D_DEADC0DE_FEEDFACE_C001D00D;
    localparam logic [127:0] c_D4  = 128'h00000001_00000002_00000003_00000004;
    localparam logic [127:0] c_D5  = 128'h77777777_55555555_33333333_11111111;
    localparam logic [127:0] c_D6  = 128'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC;

    initial begin
        logic [127:0] rd;
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        #2;
        chk("reset/mem_ready", 128'(mem_ready), 128'(0));
        chk("reset/busy",      128'(busy),      128'(0));
        chk("reset/err",       128'(err),       128'(0));
        chk("reset/mem_rdata", mem_rdata,       128'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Write, then read back the same line
        run("wr12", 1'b0, 1'b1, 32'h0000_0120, c_D1, 0, 1'b0, rd);
        chk("wr12/rdata_unchanged", rd, 128'(0));
        run("rd12", 1'b1, 1'b0, 32'h0000_0120, '0, 0, 1'b0, rd);
        chk("rd12/rdata", rd, c_D1);

        // Request held for two cycles after mem_ready: still only one pulse
        run("hold", 1'b1, 1'b0, 32'h0000_0120, '0, 2, 1'b0, rd);
        chk("hold/rdata", rd, c_D1);

        // Address/data changed mid-BUSY are ignored
        run("wr34", 1'b0, 1'b1, 32'h0000_0340, c_D34, 0, 1'b0, rd);
        run("wr12chg", 1'b0, 1'b1, 32'h0000_0120, c_D2, 0, 1'b1, rd);
        run("rd12chg", 1'b1, 1'b0, 32'h0000_0120, '0, 0, 1'b1, rd);
        chk("rd12chg/rdata", rd, c_D2);
        run("rd34", 1'b1, 1'b0, 32'h0000_0340, '0, 0, 1'b0, rd);
        chk("rd34/untouched", rd, c_D34);
        chk("rd34/err_clear", 128'(err), 128'(0));

        // Read and write together: write commits, err is sticky
        run("both", 1'b1, 1'b1, 32'h0000_0560, c_D3, 0, 1'b0, rd);
        chk("both/err", 128'(err), 128'(1));
        chk("both/rdata_held", rd, c_D34);
        run("rd56", 1'b1, 1'b0, 32'h0000_0560, '0, 0, 1'b0, rd);
        chk("rd56/rdata", rd, c_D3);
        chk("rd56/err_sticky", 128'(err), 128'(1));

        // Index alias: line 0x101 maps onto line 0x001
        run("wr001", 1'b0, 1'b1, 32'h0000_0010, c_D4, 0, 1'b0, rd);
        run("rd101", 1'b1, 1'b0, 32'h0000_1010, '0, 0, 1'b0, rd);
        chk("rd101/alias", rd, c_D4);

        // Commit D5 to line 0x77, then reset in the middle of overwriting it
        run("wr77", 1'b0, 1'b1, 32'h0000_0770, c_D5, 0, 1'b0, rd);
        run("rd77", 1'b1, 1'b0, 32'h0000_0770, '0, 0, 1'b0, rd);
        chk("rd77/rdata", rd, c_D5);
        @(negedge clk);
        mem_write = 1'b1;
        mem_addr  = 28'h0000_077;
        mem_wdata = c_D6;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst/mem_ready", 128'(mem_ready), 128'(0));
        chk("midrst/busy",      128'(busy),      128'(0));
        chk("midrst/err",       128'(err),       128'(0));
        chk("midrst/mem_rdata", mem_rdata,       128'(0));
        mem_write = 1'b0;
        mem_wdata = '0;
        @(negedge clk);
        rst_n = 1'b1;
        run("postrst", 1'b1, 1'b0, 32'h0000_0770, '0, 0, 1'b0, rd);
        chk("postrst/lost_write", rd, c_D5);
        chk("postrst/err", 128'(err), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
